// File: rtl/multicycle_control_pkg.sv
// Shared CPU constants for the multicycle controller: opcodes, mux/ALU encodings, states.
// MULTICYCLE_LINK_EN adds the LINK state and the linkDst control field.
package multicycle_control_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FunctJr   = 6'b001000;
    localparam logic [5:0] FunctJalr = 6'b001001;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluImm   = 2'b11;

    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBBranch = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcReg    = 2'b11;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAddr = 4'd2,
        StMemRead = 4'd3,
        StMemWb   = 4'd4,
        StMemWrite = 4'd5,
        StExec    = 4'd6,
        StAluWb   = 4'd7,
        StImmExec = 4'd8,
        StImmWb   = 4'd9,
        StBranch  = 4'd10,
        StJump    = 4'd11,
        StJumpReg = 4'd12,
`ifdef MULTICYCLE_LINK_EN
        StLink    = 4'd13,
`endif
        StHalt    = 4'd14
    } stateT;

    typedef enum logic [2:0] {
        ClsMem, ClsRtype, ClsJumpReg, ClsImm, ClsBranch, ClsJump, ClsIllegal
    } dispatchT;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcWriteCondNe;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       memtoReg;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic [1:0] aluSrcB;
`ifdef MULTICYCLE_LINK_EN
        logic       linkDst;
`endif
    } ctrlT;

    // States that wait on the memory handshake and own the wait counter.
    function automatic logic isWaitState(input stateT s);
        return s inside {StFetch, StMemRead, StMemWrite};
    endfunction

endpackage

// File: rtl/multicycle_dispatch.sv
// Combinational opcode/funct decode into the DECODE-state dispatch class.
// With MULTICYCLE_LINK_EN, JAL/JALR dispatch to jumps that also request a link writeback.
module multicycle_dispatch
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dispatchT   cls
`ifdef MULTICYCLE_LINK_EN
    ,
    output logic       link
`endif
);

    always_comb begin
        cls = ClsIllegal;
`ifdef MULTICYCLE_LINK_EN
        link = 1'b0;
`endif
        case (opcode)
            OpLw, OpSw: cls = ClsMem;
            OpRtype: begin
                if (funct == FunctJr) begin
                    cls = ClsJumpReg;
                end else if (funct == FunctJalr) begin
`ifdef MULTICYCLE_LINK_EN
                    cls  = ClsJumpReg;
                    link = 1'b1;
`else
                    cls = ClsIllegal;
`endif
                end else begin
                    cls = ClsRtype;
                end
            end
            OpAddi, OpAndi, OpOri, OpXori, OpSlti, OpLui: cls = ClsImm;
            OpBeq, OpBne: cls = ClsBranch;
            OpJ: cls = ClsJump;
            OpJal: begin
`ifdef MULTICYCLE_LINK_EN
                cls  = ClsJump;
                link = 1'b1;
`else
                cls = ClsIllegal;
`endif
            end
            default: cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory-wait timeout and absorbing fault HALT.
// MULTICYCLE_LINK_EN adds the LINK writeback state for JAL/JALR and the linkDst output.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcWriteCondNe,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memtoReg,
    output logic       regWrite,
    output logic       regDst,
    output logic       aluSrcA,
    output logic [1:0] pcSource,
    output logic [1:0] aluOp,
    output logic [1:0] aluSrcB,
    output logic [3:0] state,
    output logic       instrDone,
    output logic       fault
`ifdef MULTICYCLE_LINK_EN
    ,
    output logic       linkDst
`endif
);

    stateT      stateQ, stateD;
    logic [3:0] waitQ, waitD, waitInc;
    logic [5:0] opQ;
    logic       instrDoneQ;
    dispatchT   cls;
    ctrlT       ctrl, ctrlGated;
    logic       unusedZero;
`ifdef MULTICYCLE_LINK_EN
    logic       linkQ, linkNew;
`endif

    // Branch qualification by zero happens in the datapath, not here.
    assign unusedZero = zero;
    assign waitInc    = waitQ + 4'd1;

    multicycle_dispatch uDispatch (
        .opcode (opcode),
        .funct  (funct),
        .cls    (cls)
`ifdef MULTICYCLE_LINK_EN
        ,
        .link   (linkNew)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= StFetch;
            waitQ      <= '0;
            opQ        <= '0;
            instrDoneQ <= 1'b0;
`ifdef MULTICYCLE_LINK_EN
            linkQ      <= 1'b0;
`endif
        end else begin
            stateQ     <= stateD;
            waitQ      <= waitD;
            instrDoneQ <= (stateD == StFetch) && (stateQ != StFetch);
            if (stateQ == StDecode) begin
                opQ <= opcode;
`ifdef MULTICYCLE_LINK_EN
                linkQ <= linkNew;
`endif
            end
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StFetch: begin
                if (memReady)                         stateD = StDecode;
                else if (waitInc == 4'(WAIT_LIMIT))   stateD = StHalt;
            end
            StDecode: begin
                case (cls)
                    ClsMem:     stateD = StMemAddr;
                    ClsRtype:   stateD = StExec;
                    ClsJumpReg: stateD = StJumpReg;
                    ClsImm:     stateD = StImmExec;
                    ClsBranch:  stateD = StBranch;
                    ClsJump:    stateD = StJump;
                    default:    stateD = StHalt;
                endcase
            end
            StMemAddr: stateD = (opQ == OpSw) ? StMemWrite : StMemRead;
            StMemRead: begin
                if (memReady)                         stateD = StMemWb;
                else if (waitInc == 4'(WAIT_LIMIT))   stateD = StHalt;
            end
            StMemWrite: begin
                if (memReady)                         stateD = StFetch;
                else if (waitInc == 4'(WAIT_LIMIT))   stateD = StHalt;
            end
            StMemWb, StAluWb, StImmWb, StBranch: stateD = StFetch;
            StExec:    stateD = StAluWb;
            StImmExec: stateD = StImmWb;
`ifdef MULTICYCLE_LINK_EN
            StJump, StJumpReg: stateD = linkQ ? StLink : StFetch;
            StLink:            stateD = StFetch;
`else
            StJump, StJumpReg: stateD = StFetch;
`endif
            default: stateD = StHalt;
        endcase

        // Counter restarts on entry to a wait state and counts memReady-low cycles there.
        waitD = waitQ;
        if ((stateD != stateQ) && isWaitState(stateD)) begin
            waitD = '0;
        end else if (isWaitState(stateQ) && !memReady) begin
            waitD = waitInc;
        end
    end

    always_comb begin
        ctrl = '0;
        case (stateQ)
            StFetch: begin
                ctrl.memRead = 1'b1;
                if (memReady) begin
                    ctrl.irWrite  = 1'b1;
                    ctrl.pcWrite  = 1'b1;
                    ctrl.aluSrcB  = SrcBFour;
                    ctrl.aluOp    = AluAdd;
                    ctrl.pcSource = PcAlu;
                end
            end
            StDecode: begin
                ctrl.aluSrcB = SrcBBranch;
                ctrl.aluOp   = AluAdd;
            end
            StMemAddr: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SrcBImm;
                ctrl.aluOp   = AluAdd;
            end
            StMemRead: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            StMemWb: begin
                ctrl.regWrite = 1'b1;
                ctrl.memtoReg = 1'b1;
            end
            StMemWrite: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            StExec: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SrcBReg;
                ctrl.aluOp   = AluFunct;
            end
            StAluWb: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            StImmExec: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SrcBImm;
                ctrl.aluOp   = (opQ == OpAddi) ? AluAdd : AluImm;
            end
            StImmWb: ctrl.regWrite = 1'b1;
            StBranch: begin
                ctrl.aluSrcA       = 1'b1;
                ctrl.aluSrcB       = SrcBReg;
                ctrl.aluOp         = AluSub;
                ctrl.pcSource      = PcAluOut;
                ctrl.pcWriteCond   = (opQ == OpBeq);
                ctrl.pcWriteCondNe = (opQ == OpBne);
            end
            StJump: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PcJump;
            end
            StJumpReg: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PcReg;
            end
`ifdef MULTICYCLE_LINK_EN
            StLink: begin
                ctrl.regWrite = 1'b1;
                ctrl.linkDst  = (opQ == OpJal);
            end
`endif
            default: ;
        endcase
    end

    // Reset forces FETCH, whose memRead must still stay quiet while rst_n is low.
    assign ctrlGated = rst_n ? ctrl : '0;

    assign pcWrite       = ctrlGated.pcWrite;
    assign pcWriteCond   = ctrlGated.pcWriteCond;
    assign pcWriteCondNe = ctrlGated.pcWriteCondNe;
    assign iorD          = ctrlGated.iorD;
    assign memRead       = ctrlGated.memRead;
    assign memWrite      = ctrlGated.memWrite;
    assign irWrite       = ctrlGated.irWrite;
    assign memtoReg      = ctrlGated.memtoReg;
    assign regWrite      = ctrlGated.regWrite;
    assign regDst        = ctrlGated.regDst;
    assign aluSrcA       = ctrlGated.aluSrcA;
    assign pcSource      = ctrlGated.pcSource;
    assign aluOp         = ctrlGated.aluOp;
    assign aluSrcB       = ctrlGated.aluSrcB;
`ifdef MULTICYCLE_LINK_EN
    assign linkDst       = ctrlGated.linkDst;
`endif

    assign state     = stateQ;
    assign instrDone = instrDoneQ;
    assign fault     = (stateQ == StHalt);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle scoreboard of expected state and control word.
// Builds with or without MULTICYCLE_LINK_EN.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int PCW = 18, PCC = 17, PCN = 16, IORD = 15, MRD = 14, MWR = 13, IRW = 12;
    localparam int M2R = 11, RW = 10, RDST = 9, SRCA = 8, DONE = 1, FLT = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       memReady = 1'b0;
    logic       pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite;
    logic       memtoReg, regWrite, regDst, aluSrcA, instrDone, fault;
    logic [1:0] pcSource, aluOp, aluSrcB;
    logic [3:0] state;
`ifdef MULTICYCLE_LINK_EN
    logic       linkDst;
`endif

    logic [18:0] obsCw;
    logic [22:0] sb[$];
    int compared = 0;
    int mismatched = 0;

    logic [18:0] cwFetchRdy, cwFetchWait, cwDec, cwMemAddr, cwMemRead, cwMemWb, cwMemWrite;
    logic [18:0] cwExec, cwAluWb, cwImmAdd, cwImmOther, cwImmWb, cwBeq, cwBne, cwJump;
    logic [18:0] cwJumpReg, cwHalt, cwDone, cwLink;

    multicycle_control #(.WAIT_LIMIT(15)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .memReady      (memReady),
        .pcWrite       (pcWrite),
        .pcWriteCond   (pcWriteCond),
        .pcWriteCondNe (pcWriteCondNe),
        .iorD          (iorD),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .irWrite       (irWrite),
        .memtoReg      (memtoReg),
        .regWrite      (regWrite),
        .regDst        (regDst),
        .aluSrcA       (aluSrcA),
        .pcSource      (pcSource),
        .aluOp         (aluOp),
        .aluSrcB       (aluSrcB),
        .state         (state),
        .instrDone     (instrDone),
        .fault         (fault)
`ifdef MULTICYCLE_LINK_EN
        ,
        .linkDst       (linkDst)
`endif
    );

    always #5 clk = ~clk;

    assign obsCw = {pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite,
                    memtoReg, regWrite, regDst, aluSrcA, pcSource, aluOp, aluSrcB, instrDone, fault};

    function automatic logic [18:0] b(input int i);
        return 19'(1) << i;
    endfunction

    function automatic logic [18:0] f(input logic [1:0] pcs, input logic [1:0] op,
                                      input logic [1:0] srcB);
        return {11'b0, pcs, op, srcB, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive memReady, queue the expectation, check, advance one cycle.
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] expSt,
                       input logic [18:0] expCw);
        logic [22:0] e;
        memReady = rdy;
        sb.push_back({expSt, expCw});
        #1;
        e = sb.pop_front();
        check({tag, ".state"}, 32'(state), 32'(e[22:19]));
        check({tag, ".ctrl"}, 32'(obsCw), 32'(e[18:0]));
        @(negedge clk);
    endtask

    // Asserts reset off the clock edge, checks the asynchronous effect, releases on a falling edge.
    task automatic resetPulse(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".state"}, 32'(state), 32'(StFetch));
        check({tag, ".ctrl"}, 32'(obsCw), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cwFetchRdy  = b(PCW) | b(MRD) | b(IRW) | f(2'b00, 2'b00, 2'b01);
        cwFetchWait = b(MRD);
        cwDec       = f(2'b00, 2'b00, 2'b11);
        cwMemAddr   = b(SRCA) | f(2'b00, 2'b00, 2'b10);
        cwMemRead   = b(MRD) | b(IORD);
        cwMemWb     = b(RW) | b(M2R);
        cwMemWrite  = b(MWR) | b(IORD);
        cwExec      = b(SRCA) | f(2'b00, 2'b10, 2'b00);
        cwAluWb     = b(RW) | b(RDST);
        cwImmAdd    = b(SRCA) | f(2'b00, 2'b00, 2'b10);
        cwImmOther  = b(SRCA) | f(2'b00, 2'b11, 2'b10);
        cwImmWb     = b(RW);
        cwBeq       = b(SRCA) | b(PCC) | f(2'b01, 2'b01, 2'b00);
        cwBne       = b(SRCA) | b(PCN) | f(2'b01, 2'b01, 2'b00);
        cwJump      = b(PCW) | f(2'b10, 2'b00, 2'b00);
        cwJumpReg   = b(PCW) | f(2'b11, 2'b00, 2'b00);
        cwHalt      = b(FLT);
        cwDone      = b(DONE);
        cwLink      = b(RW);

        // Reset held with memReady high: FETCH state but every strobe quiet.
        memReady = 1'b1;
        @(negedge clk);
        cyc("rst0", 1'b1, StFetch, 19'd0);
        cyc("rst1", 1'b1, StFetch, 19'd0);
        rst_n = 1'b1;

        opcode = 6'b100011; // LW
        cyc("lw.f", 1'b1, StFetch, cwFetchRdy);
        cyc("lw.d", 1'b0, StDecode, cwDec);
        cyc("lw.a", 1'b0, StMemAddr, cwMemAddr);
        cyc("lw.r", 1'b1, StMemRead, cwMemRead);
        cyc("lw.wb", 1'b0, StMemWb, cwMemWb);

        opcode = 6'b000000; funct = 6'b100000; // ADD
        cyc("add.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("add.d", 1'b0, StDecode, cwDec);
        cyc("add.x", 1'b0, StExec, cwExec);
        cyc("add.wb", 1'b0, StAluWb, cwAluWb);

        opcode = 6'b001000; // ADDI
        cyc("addi.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("addi.d", 1'b0, StDecode, cwDec);
        cyc("addi.x", 1'b0, StImmExec, cwImmAdd);
        cyc("addi.wb", 1'b0, StImmWb, cwImmWb);

        opcode = 6'b001101; // ORI, two fetch wait cycles; instrDone only in the first
        cyc("ori.f0", 1'b0, StFetch, cwFetchWait | cwDone);
        cyc("ori.f1", 1'b0, StFetch, cwFetchWait);
        cyc("ori.f2", 1'b1, StFetch, cwFetchRdy);
        cyc("ori.d", 1'b0, StDecode, cwDec);
        cyc("ori.x", 1'b0, StImmExec, cwImmOther);
        cyc("ori.wb", 1'b0, StImmWb, cwImmWb);

        zero = 1'b1;
        opcode = 6'b000100; // BEQ
        cyc("beq.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("beq.d", 1'b0, StDecode, cwDec);
        cyc("beq.br", 1'b0, StBranch, cwBeq);
        opcode = 6'b000101; // BNE
        cyc("bne.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("bne.d", 1'b0, StDecode, cwDec);
        cyc("bne.br", 1'b0, StBranch, cwBne);
        zero = 1'b0;

        opcode = 6'b000010; // J
        cyc("j.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("j.d", 1'b0, StDecode, cwDec);
        cyc("j.j", 1'b0, StJump, cwJump);
        opcode = 6'b000000; funct = 6'b001000; // JR
        cyc("jr.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("jr.d", 1'b0, StDecode, cwDec);
        cyc("jr.j", 1'b0, StJumpReg, cwJumpReg);

        opcode = 6'b101011; // SW with three wait cycles in MEMWRITE
        cyc("sw.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("sw.d", 1'b0, StDecode, cwDec);
        cyc("sw.a", 1'b0, StMemAddr, cwMemAddr);
        cyc("sw.w0", 1'b0, StMemWrite, cwMemWrite);
        cyc("sw.w1", 1'b0, StMemWrite, cwMemWrite);
        cyc("sw.w2", 1'b0, StMemWrite, cwMemWrite);
        check("sw.waitcount", 32'(dut.waitQ), 32'd3);
        cyc("sw.w3", 1'b1, StMemWrite, cwMemWrite);

        opcode = 6'b111111; // illegal opcode
        cyc("ill.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("ill.d", 1'b0, StDecode, cwDec);
        for (int i = 0; i < 3; i++) cyc("ill.halt", 1'b1, StHalt, cwHalt);
        resetPulse("rst.ill");

        opcode = 6'b000011; // JAL
        cyc("jal.f", 1'b1, StFetch, cwFetchRdy);
        cyc("jal.d", 1'b0, StDecode, cwDec);
`ifdef MULTICYCLE_LINK_EN
        cyc("jal.j", 1'b0, StJump, cwJump);
        check("jal.linkDst", 32'(linkDst), 32'd1);
        cyc("jal.link", 1'b0, StLink, cwLink);
        opcode = 6'b000000; funct = 6'b001001; // JALR
        cyc("jalr.f", 1'b1, StFetch, cwFetchRdy | cwDone);
        cyc("jalr.d", 1'b0, StDecode, cwDec);
        cyc("jalr.j", 1'b0, StJumpReg, cwJumpReg);
        check("jalr.linkDst", 32'(linkDst), 32'd0);
        cyc("jalr.link", 1'b0, StLink, cwLink);
        cyc("jalr.done", 1'b0, StFetch, cwFetchWait | cwDone);
`else
        cyc("jal.halt", 1'b0, StHalt, cwHalt);
`endif
        resetPulse("rst.jal");

        // Fetch timeout: 15 low cycles in FETCH, then sticky HALT.
        for (int i = 0; i < 15; i++) cyc("to.fetch", 1'b0, StFetch, cwFetchWait);
        cyc("to.halt0", 1'b0, StHalt, cwHalt);
        for (int i = 0; i < 3; i++) cyc("to.halt", 1'b1, StHalt, cwHalt);
        resetPulse("rst.to");

        // Reset in the middle of a store abandons it.
        opcode = 6'b101011;
        cyc("ab.f", 1'b1, StFetch, cwFetchRdy);
        cyc("ab.d", 1'b0, StDecode, cwDec);
        cyc("ab.a", 1'b0, StMemAddr, cwMemAddr);
        cyc("ab.w", 1'b0, StMemWrite, cwMemWrite);
        resetPulse("rst.ab");
        cyc("ab.post0", 1'b0, StFetch, cwFetchWait);
        cyc("ab.post1", 1'b0, StFetch, cwFetchWait);

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 15, meaning the maximum memory wait cycles before fault (range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 The block SHALL have port funct, input, 6, instruction bits [5:0].
REQ-006 The block SHALL have port zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have port memReady, input, 1, memory access-complete handshake.
REQ-008 The block SHALL have control outputs pcWrite, pcWriteCond, pcWriteCondNe, iorD, memRead, memWrite, irWrite, memtoReg, regWrite, regDst, aluSrcA, each 1 bit.
REQ-009 The block SHALL have outputs pcSource (2), aluOp (2), aluSrcB (2), state (4, debug), instrDone (1), fault (1).

Function
REQ-010 The states SHALL be FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, IMMEXEC, IMMWB, BRANCH, JUMP, JUMPREG, LINK, and HALT.
REQ-011 Transitions out of FETCH SHALL be: FETCH->DECODE only when memReady=1; otherwise stay in FETCH.
REQ-012 FETCH SHALL assert memRead and iorD=0, and SHALL assert irWrite, pcWrite, aluSrcA=0, aluSrcB=01, aluOp=00 (Add) and pcSource=00 only in the memReady cycle.
REQ-013 DECODE SHALL assert aluSrcA=0, aluSrcB=11 and aluOp=00 (branch target precompute).
REQ-014 DECODE SHALL dispatch as follows: LW/SW->MEMADDR; R-type->EXEC, except funct JR/JALR->JUMPREG; ADDI/ANDI/ORI/XORI/SLTI/LUI->IMMEXEC; BEQ/BNE->BRANCH; J/JAL->JUMP; any other opcode->HALT with fault=1.
REQ-015 MEMADDR SHALL assert aluSrcA=1, aluSrcB=10 and aluOp=00, then go to MEMREAD (LW) or MEMWRITE (SW).
REQ-016 MEMREAD SHALL assert memRead and iorD=1, and SHALL hold until memReady, then go to MEMWB.
REQ-017 MEMWB SHALL assert regWrite and memtoReg with regDst=0, then go to FETCH.
REQ-018 MEMWRITE SHALL assert memWrite and iorD=1 and SHALL hold until memReady, then go to FETCH.
REQ-019 EXEC SHALL assert aluSrcA=1, aluSrcB=00 and aluOp=10; ALUWB SHALL assert regWrite and regDst=1.
REQ-020 IMMEXEC SHALL assert aluSrcA=1, aluSrcB=10, and aluOp=00 for ADDI, 11 (Immediate) otherwise; IMMWB SHALL assert regWrite with regDst=0.
REQ-021 BRANCH SHALL assert aluSrcA=1, aluSrcB=00, aluOp=01 and pcSource=01, plus pcWriteCond for BEQ or pcWriteCondNe for BNE; it then goes to FETCH.
REQ-022 JUMP SHALL assert pcWrite with pcSource=10; JUMPREG SHALL assert pcWrite with pcSource=11.
REQ-023 instrDone SHALL pulse for one cycle on every transition into FETCH from a non-reset state.
REQ-024 A 4-bit wait counter SHALL clear on entry to FETCH, MEMREAD or MEMWRITE and SHALL increment each cycle memReady=0 in those states.
REQ-025 When the wait counter reaches WAIT_LIMIT, the block SHALL go to HALT with fault=1.
REQ-026 HALT SHALL be absorbing: all strobes 0 and fault held at 1 until reset.
REQ-027 Any control output not listed for the current state SHALL be 0.
REQ-028 Strobes SHALL be Moore outputs (decoded from state, registered opcode and memReady) and SHALL never be asserted in two consecutive states unless listed for both.

Reset
REQ-029 While rst_n=0, the block SHALL force state=FETCH, wait counter=0, fault=0 and instrDone=0.
REQ-030 While rst_n=0, all strobes SHALL be 0, including memRead.
REQ-031 Deassertion of rst_n SHALL begin fetch on the next edge.
REQ-032 Reset mid-access SHALL abandon the access, and no write strobe SHALL be issued after reset.

Configuration
REQ-033 With MULTICYCLE_LINK_EN defined, JAL SHALL go JUMP->LINK and JALR SHALL go JUMPREG->LINK; LINK SHALL assert regWrite with memtoReg=0 and the link select (regDst=0, destination forced to $ra for JAL or rd for JALR via an added linkDst output), then go to FETCH.
REQ-034 Without MULTICYCLE_LINK_EN, the LINK state and linkDst output SHALL be absent, and JAL/JALR SHALL go to HALT with fault=1.

Structure
REQ-035 Opcode/funct codes, aluOp encodings (Add 00, Sub 01, Funct 10, Immediate 11), aluSrcB and pcSource encodings, and the state enumeration SHALL live in the shared CPU constants include.
REQ-036 The opcode-to-dispatch decode SHALL be one sub-module, multicycle_dispatch, which is purely combinational (opcode, funct) -> next-state class.

Verification
REQ-037 LW with memReady high each access -> FETCH, DECODE, MEMADDR, MEMREAD, MEMWB; exactly 5 cycles, one regWrite with memtoReg=1, one instrDone pulse.
REQ-038 BEQ with zero=1 -> pcWriteCond=1 and pcSource=01 in cycle 3; BNE with zero=1 -> pcWriteCondNe=1, and PC unchanged by the datapath.
REQ-039 SW with memReady held low 3 cycles in MEMWRITE -> memWrite held 4 cycles, wait counter reaches 3, no fault.
REQ-040 memReady held low 15 cycles in FETCH (WAIT_LIMIT=15) -> HALT, fault=1 sticky, no strobes until rst_n pulse.
REQ-041 opcode 111111 -> HALT from DECODE with fault=1; JAL with MULTICYCLE_LINK_EN -> LINK with regWrite=1; JAL without it -> HALT.
REQ-042 rst_n asserted during MEMWRITE -> memWrite drops asynchronously, state=FETCH, fault=0.
